hazard_stall_unit: RTL and testbench

Pipeline stall/flush controller sitting in the ID stage, alongside the two forwarding units. Forwarding covers EX→EX and EX→ID-branch operand paths. This block handles the cases forwarding cannot:
- load-use hazards;
- branches in ID whose operands are still in flight;
- taken-branch flushes of IF/ID.

It drives the PC, IF/ID and ID/EX pipeline-register controls, holds multi-cycle stalls with an internal FSM and counter, and keeps a saturating stall-cycle performance counter.

---
 rtl/hazard_stall_unit_pkg.sv | 20 ++
 rtl/hazard_stall_unit_len_calc.sv | 34 +++
 rtl/hazard_stall_unit.sv | 109 ++++++++++
 tb/tb_hazard_stall_unit.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/hazard_stall_unit_pkg.sv
// Shared types and constants for the ID-stage hazard/stall controller.
package hazard_stall_unit_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    STALL = 2'b01,
    FLUSH = 2'b10
  } state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // A producer register conflicts with ID when it is nonzero and read by ID.
  function automatic logic reg_hit(input logic [4:0] r,
                                   input logic [4:0] rs,
                                   input logic [4:0] rt,
                                   input logic       uses_rt);
    return (r != REG_ZERO) && ((r == rs) || (uses_rt && (r == rt)));
  endfunction

endpackage

// File: rtl/hazard_stall_unit_len_calc.sv
// Combinational stall-length decode: how many cycles ID must wait for its operands.
module hazard_len_calc
  import hazard_stall_unit_pkg::*;
(
  input  logic [4:0] ID_rs,
  input  logic [4:0] ID_rt,
  input  logic       ID_uses_rt,
  input  logic       Branch,
  input  logic       EX_MemRead,
  input  logic       EX_RegWrite,
  input  logic [4:0] EX_Reg_Write,
  input  logic       MEM_MemRead,
  input  logic [4:0] MEM_Reg_Write,
  output logic [1:0] stall_len
);

  logic ex_hit;
  logic mem_hit;

  always_comb begin
    ex_hit  = reg_hit(EX_Reg_Write, ID_rs, ID_rt, ID_uses_rt);
    mem_hit = reg_hit(MEM_Reg_Write, ID_rs, ID_rt, ID_uses_rt);
    stall_len = 2'd0;
    if (Branch && EX_MemRead && ex_hit)
      stall_len = 2'd2;
    else if (Branch && EX_RegWrite && !EX_MemRead && ex_hit)
      stall_len = 2'd1;
    else if (Branch && MEM_MemRead && mem_hit)
      stall_len = 2'd1;
    else if (!Branch && EX_MemRead && ex_hit)
      stall_len = 2'd1;
  end

endmodule

// File: rtl/hazard_stall_unit.sv
// ID-stage stall/flush controller: load-use and branch-operand stalls, taken-branch
// flushes of IF/ID, and a saturating stall-cycle counter.
module hazard_stall_unit
  import hazard_stall_unit_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       ID_rs,
  input  logic [4:0]       ID_rt,
  input  logic             ID_uses_rt,
  input  logic             Branch,
  input  logic             Branch_taken,
  input  logic             EX_MemRead,
  input  logic             EX_RegWrite,
  input  logic [4:0]       EX_Reg_Write,
  input  logic             MEM_MemRead,
  input  logic [4:0]       MEM_Reg_Write,
  output logic             PC_Write,
  output logic             IF_ID_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Bubble,
  output logic             stall_active,
  output logic [CNT_W-1:0] stall_cycles
);

  state_e           state_q, state_d;
  logic [1:0]       rem_q, rem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       stall_len;
  logic             stall_now;
  logic             flush_now;

  hazard_len_calc u_len (
    .ID_rs         (ID_rs),
    .ID_rt         (ID_rt),
    .ID_uses_rt    (ID_uses_rt),
    .Branch        (Branch),
    .EX_MemRead    (EX_MemRead),
    .EX_RegWrite   (EX_RegWrite),
    .EX_Reg_Write  (EX_Reg_Write),
    .MEM_MemRead   (MEM_MemRead),
    .MEM_Reg_Write (MEM_Reg_Write),
    .stall_len     (stall_len)
  );

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    stall_now = 1'b0;
    flush_now = 1'b0;
    case (state_q)
      STALL: begin
        // rem_q counts stall cycles still owed after the detecting cycle;
        // this cycle pays one of them.
        stall_now = 1'b1;
        rem_d     = rem_q - 2'd1;
        if (rem_q <= 2'd1) begin
          state_d = RUN;
          rem_d   = '0;
        end
      end
      default: begin
        if (stall_len != 2'd0) begin
          stall_now = 1'b1;
          if (stall_len > 2'd1) begin
            state_d = STALL;
            rem_d   = stall_len - 2'd1;
          end else begin
            state_d = RUN;
          end
        end else if (Branch && Branch_taken) begin
          flush_now = 1'b1;
          state_d   = FLUSH;
        end else begin
          state_d = RUN;
        end
      end
    endcase

    cnt_d = cnt_q;
    if (stall_now && (cnt_q != '1))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      rem_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
    end
  end

  // While reset is held the decode still runs, but its effect on outputs is masked.
  always_comb begin
    ID_EX_Bubble = rst & stall_now;
    PC_Write     = ~ID_EX_Bubble;
    IF_ID_Write  = ~ID_EX_Bubble;
    IF_ID_Flush  = rst & flush_now;
    stall_active = (state_q == STALL);
    stall_cycles = cnt_q;
  end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed-vector bench for hazard_stall_unit with a queue-based scoreboard.
module tb_hazard_stall_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  ID_rs, ID_rt, EX_Reg_Write, MEM_Reg_Write;
  logic        ID_uses_rt, Branch, Branch_taken, EX_MemRead, EX_RegWrite, MEM_MemRead;
  logic        PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, stall_active;
  logic [15:0] stall_cycles;
  logic        s_PC_Write, s_IF_ID_Write, s_IF_ID_Flush, s_ID_EX_Bubble, s_stall_active;
  logic [1:0]  s_stall_cycles;

  always #5 clk = ~clk;

  hazard_stall_unit #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_uses_rt(ID_uses_rt),
    .Branch(Branch), .Branch_taken(Branch_taken), .EX_MemRead(EX_MemRead),
    .EX_RegWrite(EX_RegWrite), .EX_Reg_Write(EX_Reg_Write), .MEM_MemRead(MEM_MemRead),
    .MEM_Reg_Write(MEM_Reg_Write), .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write),
    .IF_ID_Flush(IF_ID_Flush), .ID_EX_Bubble(ID_EX_Bubble), .stall_active(stall_active),
    .stall_cycles(stall_cycles)
  );

  hazard_stall_unit #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_uses_rt(ID_uses_rt),
    .Branch(Branch), .Branch_taken(Branch_taken), .EX_MemRead(EX_MemRead),
    .EX_RegWrite(EX_RegWrite), .EX_Reg_Write(EX_Reg_Write), .MEM_MemRead(MEM_MemRead),
    .MEM_Reg_Write(MEM_Reg_Write), .PC_Write(s_PC_Write), .IF_ID_Write(s_IF_ID_Write),
    .IF_ID_Flush(s_IF_ID_Flush), .ID_EX_Bubble(s_ID_EX_Bubble),
    .stall_active(s_stall_active), .stall_cycles(s_stall_cycles)
  );

  typedef struct {
    string name;
    bit    pcw, ifw, fl, bub, act;
    int    cnt, cnt2;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input string fld, input int act_v, input int exp_v);
    total++;
    if (act_v != exp_v) begin
      bad++;
      $display("FAIL %s.%s: got %0d expected %0d", name, fld, act_v, exp_v);
    end
  endtask

  // Monitor: outputs are combinational, so every cycle presents a response at negedge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk(e.name, "PC_Write",     int'(PC_Write),       int'(e.pcw));
        chk(e.name, "IF_ID_Write",  int'(IF_ID_Write),    int'(e.ifw));
        chk(e.name, "IF_ID_Flush",  int'(IF_ID_Flush),    int'(e.fl));
        chk(e.name, "ID_EX_Bubble", int'(ID_EX_Bubble),   int'(e.bub));
        chk(e.name, "stall_active", int'(stall_active),   int'(e.act));
        chk(e.name, "stall_cycles", int'(stall_cycles),   e.cnt);
        chk(e.name, "sat_cycles",   int'(s_stall_cycles), e.cnt2);
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set(input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                     input logic br, input logic tk, input logic exmr, input logic exrw,
                     input logic [4:0] exrd, input logic memmr, input logic [4:0] memrd);
    ID_rs = rs; ID_rt = rt; ID_uses_rt = urt; Branch = br; Branch_taken = tk;
    EX_MemRead = exmr; EX_RegWrite = exrw; EX_Reg_Write = exrd;
    MEM_MemRead = memmr; MEM_Reg_Write = memrd;
  endtask

  task automatic idle();
    set(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
  endtask

  task automatic expect_o(input string name, input bit pcw, input bit ifw, input bit fl,
                          input bit bub, input bit act, input int cnt, input int cnt2);
    exp_t e;
    e.name = name; e.pcw = pcw; e.ifw = ifw; e.fl = fl; e.bub = bub; e.act = act;
    e.cnt = cnt; e.cnt2 = cnt2;
    q.push_back(e);
  endtask

  initial begin
    idle();
    // Hazard present while in reset: outputs must stay at reset values.
    next_cycle(); set(5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 5'd0);
    expect_o("reset_hold", 1, 1, 0, 0, 0, 0, 0);
    next_cycle(); rst = 1'b1; idle();
    expect_o("post_reset", 1, 1, 0, 0, 0, 0, 0);
    next_cycle(); set(5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 5'd0);
    expect_o("load_use", 0, 0, 0, 1, 0, 0, 0);
    next_cycle(); idle();
    expect_o("load_use_done", 1, 1, 0, 0, 0, 1, 1);
    next_cycle(); set(5'd2, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd8, 1'b0, 5'd0);
    expect_o("br_load_c1", 0, 0, 0, 1, 0, 1, 1);
    next_cycle();
    expect_o("br_load_c2", 0, 0, 0, 1, 1, 2, 2);
    next_cycle(); set(5'd2, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    expect_o("br_resolve", 1, 1, 0, 0, 0, 3, 3);
    next_cycle(); set(5'd4, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0, 5'd0);
    expect_o("taken_flush", 1, 1, 1, 0, 0, 3, 3);
    next_cycle(); idle();
    expect_o("flush_state", 1, 1, 0, 0, 0, 3, 3);
    next_cycle(); set(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0);
    expect_o("reg_zero", 1, 1, 0, 0, 0, 3, 3);
    next_cycle(); set(5'd1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd9, 1'b0, 5'd0);
    expect_o("rt_unused", 1, 1, 0, 0, 0, 3, 3);
    next_cycle(); set(5'd10, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd10, 1'b0, 5'd0);
    expect_o("br_alu", 0, 0, 0, 1, 0, 3, 3);
    next_cycle(); set(5'd3, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 5'd3);
    expect_o("stall_beats_taken", 0, 0, 0, 1, 0, 4, 3);
    next_cycle(); set(5'd3, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd3);
    expect_o("taken_after_stall", 1, 1, 1, 0, 0, 5, 3);
    next_cycle(); set(5'd12, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd12, 1'b0, 5'd0);
    expect_o("hazard_in_flush", 0, 0, 0, 1, 0, 5, 3);
    next_cycle(); idle();
    expect_o("idle_a", 1, 1, 0, 0, 0, 6, 3);
    next_cycle(); set(5'd8, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd8, 1'b0, 5'd0);
    expect_o("pre_reset_stall", 0, 0, 0, 1, 0, 6, 3);
    @(negedge clk); #1; rst = 1'b0;
    next_cycle();
    expect_o("reset_mid_stall", 1, 1, 0, 0, 0, 0, 0);
    next_cycle(); rst = 1'b1; idle();
    expect_o("after_mid_reset", 1, 1, 0, 0, 0, 0, 0);
    next_cycle(); set(5'd8, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd8, 1'b0, 5'd0);
    expect_o("sat_s1", 0, 0, 0, 1, 0, 0, 0);
    next_cycle();
    expect_o("sat_s2", 0, 0, 0, 1, 1, 1, 1);
    next_cycle(); set(5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 5'd0);
    expect_o("sat_s3", 0, 0, 0, 1, 0, 2, 2);
    next_cycle(); set(5'd0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd8, 1'b0, 5'd0);
    expect_o("sat_s4", 0, 0, 0, 1, 0, 3, 3);
    next_cycle();
    expect_o("sat_s5", 0, 0, 0, 1, 1, 4, 3);
    next_cycle(); idle();
    expect_o("sat_final", 1, 1, 0, 0, 0, 5, 3);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #1;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
